// File: rtl/ecall_service_unit.sv
// Environment-call service unit: print-int, print-hex, read-int and exit.
// Optional read-int timeout is enabled by defining ECALL_TIMEOUT_EN.
module ecall_service_unit #(
    parameter int SW_WIDTH       = 16,
    parameter int SIGN_EXT       = 0,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ecall_req,
    input  logic [31:0]         a7,
    input  logic [31:0]         a0,
    input  logic [SW_WIDTH-1:0] sw,
    input  logic                btn_confirm,
    output logic                ecall_done,
    output logic                wb_en,
    output logic [31:0]         wb_data,
    output logic [31:0]         disp_val,
    output logic                disp_hex,
    output logic                disp_valid,
    output logic                busy,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT_BTN,
        S_DONE,
        S_COOL,
        S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_a7;
    logic [31:0] r_a0;
    logic        r_btn_prev;
    logic [31:0] r_wb_data;
    logic [31:0] r_disp_val;
    logic        r_disp_hex;
    logic        r_disp_valid;
    logic        r_halted;
    logic        w_is_pint;
    logic        w_is_phex;
    logic        w_is_read;
    logic        w_is_exit;
    logic        w_btn_edge;
    logic        w_tmo_hit;
    logic [31:0] w_sw_ext;

    assign w_is_pint  = (r_a7 == 32'd1);
    assign w_is_phex  = (r_a7 == 32'd34);
    assign w_is_read  = (r_a7 == 32'd5);
    assign w_is_exit  = (r_a7 == 32'd10);
    assign w_btn_edge = btn_confirm & ~r_btn_prev;

    always_comb begin
        w_sw_ext = '0;
        w_sw_ext[SW_WIDTH-1:0] = sw;
        if (SIGN_EXT != 0 && sw[SW_WIDTH-1]) begin
            for (int i = SW_WIDTH; i < 32; i++) begin
                w_sw_ext[i] = 1'b1;
            end
        end
    end

`ifdef ECALL_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;

    assign w_tmo_hit = (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_WAIT_BTN) begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (ecall_req && !r_halted) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (1'b1)
                    w_is_pint: w_next = S_DONE;
                    w_is_phex: w_next = S_DONE;
                    w_is_read: w_next = S_WAIT_BTN;
                    w_is_exit: w_next = S_HALT;
                    default:   w_next = S_DONE;
                endcase
            end
            S_WAIT_BTN: begin
                if (w_btn_edge || w_tmo_hit) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_COOL;
            S_COOL:  w_next = S_IDLE;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a7         <= '0;
            r_a0         <= '0;
            r_btn_prev   <= 1'b1;
            r_wb_data    <= '0;
            r_disp_val   <= '0;
            r_disp_hex   <= 1'b0;
            r_disp_valid <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_btn_prev <= btn_confirm;
            if (r_state == S_IDLE && w_next == S_EXEC) begin
                r_a7 <= a7;
                r_a0 <= a0;
            end
            if (r_state == S_EXEC) begin
                if (w_is_pint || w_is_phex) begin
                    r_disp_val   <= r_a0;
                    r_disp_hex   <= w_is_phex;
                    r_disp_valid <= 1'b1;
                end
                if (w_is_exit) begin
                    r_halted <= 1'b1;
                end
                // A button already high on entry must go low first
                if (w_is_read) begin
                    r_btn_prev <= 1'b1;
                end
            end
            if (r_state == S_WAIT_BTN) begin
                if (w_btn_edge) begin
                    r_wb_data <= w_sw_ext;
                end else if (w_tmo_hit) begin
                    r_wb_data <= '0;
                end
            end
        end
    end

    assign ecall_done = (r_state == S_DONE);
    assign wb_en      = ecall_done & w_is_read;
    assign wb_data    = r_wb_data;
    assign disp_val   = r_disp_val;
    assign disp_hex   = r_disp_hex;
    assign disp_valid = r_disp_valid;
    assign busy       = (r_state != S_IDLE);
    assign halted     = r_halted;

endmodule

// File: tb/tb_ecall_service_unit.sv
// Scoreboard bench for ecall_service_unit (sign- and zero-extend instances).
// Expected completions are queued at issue and checked on ecall_done.
module tb_ecall_service_unit;

  typedef struct {
    logic        en;
    logic [31:0] d;
    logic [31:0] dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ecall_req = 1'b0;
  logic [31:0] a7 = '0;
  logic [31:0] a0 = '0;
  logic [15:0] sw = '0;
  logic        btn_confirm = 1'b0;

  logic        ecall_done, wb_en, disp_hex, disp_valid, busy, halted;
  logic [31:0] wb_data, disp_val;
  logic        done_z, wben_z, hex_z, dvld_z, busy_z, halt_z;
  logic [31:0] wbd_z, dval_z;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;

  always #5 clk = ~clk;

  ecall_service_unit #(
    .SW_WIDTH(16), .SIGN_EXT(1), .TIMEOUT_CYCLES(8)
  ) u_dut (
    .clk(clk), .rst(rst), .ecall_req(ecall_req),
    .a7(a7), .a0(a0), .sw(sw), .btn_confirm(btn_confirm),
    .ecall_done(ecall_done), .wb_en(wb_en), .wb_data(wb_data),
    .disp_val(disp_val), .disp_hex(disp_hex),
    .disp_valid(disp_valid), .busy(busy), .halted(halted)
  );

  ecall_service_unit #(
    .SW_WIDTH(16), .SIGN_EXT(0), .TIMEOUT_CYCLES(8)
  ) u_dut_z (
    .clk(clk), .rst(rst), .ecall_req(ecall_req),
    .a7(a7), .a0(a0), .sw(sw), .btn_confirm(btn_confirm),
    .ecall_done(done_z), .wb_en(wben_z), .wb_data(wbd_z),
    .disp_val(dval_z), .disp_hex(hex_z),
    .disp_valid(dvld_z), .busy(busy_z), .halted(halt_z)
  );

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ecall_done) begin
      n_done++;
      if (q.size() == 0) begin
        check("spurious_done", 32'(ecall_done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done_z", 32'(done_z), 32'd1);
        check("wb_en", 32'(wb_en), 32'(e.en));
        check("wb_en_z", 32'(wben_z), 32'(e.en));
        if (e.en) begin
          check("wb_data", wb_data, e.d);
          check("wb_data_z", wbd_z, e.dz);
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ecall_done) break;
    end
    check("done_seen", 32'(ecall_done), 32'd1);
  endtask

  task automatic do_ecall(
    input logic [31:0] c,
    input logic [31:0] v
  );
    int cyc;
    exp_t e;
    e.en = 1'b0; e.d = '0; e.dz = '0;
    q.push_back(e);
    a7 = c;
    a0 = v;
    ecall_req = 1'b1;
    @(posedge clk);
    #1;
    a7 = 32'd10;
    a0 = ~v;
    wait_done(5, cyc);
    check("lat", 32'(cyc + 1), 32'd2);
    ecall_req = 1'b0;
    step(2);
  endtask

  task automatic read_int(
    input logic [15:0] s,
    input logic pre_high,
    input logic [31:0] ed,
    input logic [31:0] edz
  );
    int cyc, d0;
    exp_t e;
    e.en = 1'b1; e.d = ed; e.dz = edz;
    q.push_back(e);
    sw = s;
    btn_confirm = pre_high;
    a7 = 32'd5;
    a0 = '0;
    ecall_req = 1'b1;
    d0 = n_done;
    step(6);
    check("rd_wait", 32'(n_done - d0), 32'd0);
    check("rd_busy", 32'(busy), 32'd1);
    if (pre_high) begin
      btn_confirm = 1'b0;
      step(1);
      check("rd_wait2", 32'(n_done - d0), 32'd0);
    end
    btn_confirm = 1'b1;
    wait_done(6, cyc);
    ecall_req = 1'b0;
    btn_confirm = 1'b0;
    step(3);
  endtask

  initial begin
    int d0, cyc;
    step(2);
    check("rst_disp", disp_val, 32'd0);
    check("rst_flags", {26'd0, ecall_done, wb_en, disp_hex,
          disp_valid, busy, halted}, 32'd0);
    check("rst_wb", wb_data, 32'd0);
    rst = 1'b1;
    step(1);

    do_ecall(32'd1, -32'sd42);
    check("pint_val", disp_val, 32'hFFFFFFD6);
    check("pint_hex", 32'(disp_hex), 32'd0);
    check("pint_vld", 32'(disp_valid), 32'd1);

    do_ecall(32'd34, 32'hDEADBEEF);
    check("phex_val", disp_val, 32'hDEADBEEF);
    check("phex_hex", 32'(disp_hex), 32'd1);

    do_ecall(32'd99, 32'h12345678);
    check("unk_val", disp_val, 32'hDEADBEEF);
    check("unk_hex", 32'(disp_hex), 32'd1);

    read_int(16'h8001, 1'b0, 32'hFFFF8001, 32'h00008001);
    check("rd_disp", disp_val, 32'hDEADBEEF);
    read_int(16'h1234, 1'b1, 32'h00001234, 32'h00001234);
    read_int(16'hFFFF, 1'b1, 32'hFFFFFFFF, 32'h0000FFFF);

`ifdef ECALL_TIMEOUT_EN
    begin
      exp_t e;
      e.en = 1'b1; e.d = '0; e.dz = '0;
      q.push_back(e);
      a7 = 32'd5;
      ecall_req = 1'b1;
      wait_done(20, cyc);
      check("tmo_lat", 32'(cyc), 32'd10);
      ecall_req = 1'b0;
      step(3);
    end
`endif

    begin
      exp_t e;
      e.en = 1'b0; e.d = '0; e.dz = '0;
      q.push_back(e);
      d0 = n_done;
      a7 = 32'd1;
      a0 = 32'd7;
      ecall_req = 1'b1;
      wait_done(5, cyc);
      step(2);
      check("cool_busy", 32'(busy), 32'd0);
      ecall_req = 1'b0;
      step(4);
      check("hold_once", 32'(n_done - d0), 32'd1);
      check("hold_val", disp_val, 32'd7);
    end

    d0 = n_done;
    btn_confirm = 1'b0;
    a7 = 32'd5;
    ecall_req = 1'b1;
    step(4);
    ecall_req = 1'b0;
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    btn_confirm = 1'b1;
    step(4);
    btn_confirm = 1'b0;
    check("abort_done", 32'(n_done - d0), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_disp", 32'(disp_valid), 32'd0);

    d0 = n_done;
    a7 = 32'd10;
    ecall_req = 1'b1;
    step(4);
    ecall_req = 1'b0;
    check("halt", 32'(halted), 32'd1);
    check("halt_busy", 32'(busy), 32'd1);
    step(1);
    a7 = 32'd1;
    a0 = 32'h55;
    ecall_req = 1'b1;
    step(6);
    ecall_req = 1'b0;
    check("halt_nodone", 32'(n_done - d0), 32'd0);
    check("halt_disp", 32'(disp_valid), 32'd0);
    rst = 1'b0;
    step(1);
    check("rst2_flags", {26'd0, ecall_done, wb_en, disp_hex,
          disp_valid, busy, halted}, 32'd0);
    check("rst2_wb", wb_data, 32'd0);
    rst = 1'b1;
    step(2);
    check("q_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
